// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: in-order store write buffer with byte-granular
// store-to-load forwarding for loads that hit pending stores.
//
// Handshake: both ports use valid/ready. A transfer happens on a rising clk
// edge when valid and ready are both high. Valid never depends on ready.
// in_ready (~full) and out_valid (~empty) are functions of registered state
// only, so neither port has a combinational path to the other.
module store_buffer_fwd #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BUFF_DEPTH = 4,
  parameter int PTR_WIDTH  = 2,
  parameter int OFF_WIDTH  = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_wstrb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_wstrb,
  input  logic [ADDR_WIDTH-1:0]   lk_addr,
  output logic                    lk_hit,
  output logic                    lk_fwd_ok,
  output logic [DATA_WIDTH-1:0]   lk_data,
  output logic [PTR_WIDTH:0]      count,
  output logic                    empty,
  output logic                    full
);

  localparam int                   NB      = DATA_WIDTH / 8;
  localparam logic [PTR_WIDTH-1:0] LAST    = PTR_WIDTH'(BUFF_DEPTH - 1);
  localparam logic [PTR_WIDTH:0]   DEPTH_C = (PTR_WIDTH + 1)'(BUFF_DEPTH);

  // Entry storage. An entry is valid from its push until its pop.
  logic [BUFF_DEPTH-1:0] ent_valid;
  logic [ADDR_WIDTH-1:0] ent_addr [BUFF_DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [BUFF_DEPTH];
  logic [NB-1:0]         ent_strb [BUFF_DEPTH];

  // head: next slot to write; tail: oldest entry.
  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH:0]   cnt;

  logic push;
  logic pop;

  // Lookup intermediates.
  logic                 hit_c;
  logic [NB-1:0]        cov_c;
  logic [DATA_WIDTH-1:0] fwd_c;
  logic [PTR_WIDTH-1:0] idx_c;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    if (p == LAST) begin
      return '0;
    end
    return p + PTR_WIDTH'(1);
  endfunction

  assign full      = (cnt == DEPTH_C);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Oldest entry drives the write side directly; popped slots read back as 0.
  assign out_addr  = ent_addr[tail];
  assign out_data  = ent_data[tail];
  assign out_wstrb = ent_strb[tail];

  // Storage, pointers and occupancy; reset wins over any push/pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ent_valid <= '0;
      for (int i = 0; i < BUFF_DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_strb[i] <= '0;
      end
    end else begin
      // Push and pop can only target the same slot when empty or full,
      // and in both cases one of them is blocked, so order here is free.
      if (pop) begin
        ent_valid[tail] <= 1'b0;
        ent_addr[tail]  <= '0;
        ent_data[tail]  <= '0;
        ent_strb[tail]  <= '0;
        tail            <= next_ptr(tail);
      end
      if (push) begin
        ent_valid[head] <= 1'b1;
        ent_addr[head]  <= in_addr;
        ent_data[head]  <= in_data;
        ent_strb[head]  <= in_wstrb;
        head            <= next_ptr(head);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_WIDTH + 1)'(1);
        2'b01:   cnt <= cnt - (PTR_WIDTH + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // RAW lookup on registered state. Walk slots from head (oldest position
  // in age order) towards head-1 (youngest), so later matches overwrite
  // earlier ones lane by lane and the youngest covering store wins.
  always_comb begin
    hit_c = 1'b0;
    cov_c = '0;
    fwd_c = '0;
    idx_c = head;
    for (int k = 0; k < BUFF_DEPTH; k++) begin
      if (ent_valid[idx_c] &&
          (ent_addr[idx_c][ADDR_WIDTH-1:OFF_WIDTH] == lk_addr[ADDR_WIDTH-1:OFF_WIDTH])) begin
        hit_c = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (ent_strb[idx_c][b]) begin
            fwd_c[8*b +: 8] = ent_data[idx_c][8*b +: 8];
            cov_c[b]        = 1'b1;
          end
        end
      end
      idx_c = next_ptr(idx_c);
    end
  end

  assign lk_hit    = hit_c;
  assign lk_fwd_ok = hit_c & (&cov_c);
  assign lk_data   = fwd_c;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// tb_store_buffer_fwd: directed and random stimulus for the store buffer,
// with an in-order scoreboard on the drain side and constant expectations
// for forwarding lookups.
module tb_store_buffer_fwd;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int DEPTH = 4;
  localparam int EW = AW + DW + NB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [NB-1:0] in_wstrb;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_wstrb;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic          lk_fwd_ok;
  logic [DW-1:0] lk_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  store_buffer_fwd #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFF_DEPTH(DEPTH), .PTR_WIDTH(2), .OFF_WIDTH(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_wstrb(in_wstrb),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_wstrb(out_wstrb),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_fwd_ok(lk_fwd_ok), .lk_data(lk_data),
    .count(count), .empty(empty), .full(full)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            mc = 0;   // model occupancy after the coming edge

  // Between edges: check flags against the model occupancy, then predict the
  // transfers the next rising edge will perform.
  always @(negedge clk) begin
    logic          push_ok;
    logic          pop_ok;
    logic [EW-1:0] e;
    if (!resetn) begin
      exp_q.delete();
      mc = 0;
    end else begin
      chk("count", EW'(count), EW'(mc));
      chk("in_ready", EW'(in_ready), EW'(mc < DEPTH));
      chk("out_valid", EW'(out_valid), EW'(mc > 0));
      chk("empty", EW'(empty), EW'(mc == 0));
      chk("full", EW'(full), EW'(mc == DEPTH));
      if (mc == 0) chk("out_idle", {out_addr, out_data, out_wstrb}, '0);
      pop_ok  = out_ready && (mc > 0);
      push_ok = in_valid && (mc < DEPTH);
      if (pop_ok) begin
        e = exp_q.pop_front();
        chk("out_entry", {out_addr, out_data, out_wstrb}, e);
      end
      if (push_ok) exp_q.push_back({in_addr, in_data, in_wstrb});
      mc = mc + int'(push_ok) - int'(pop_ok);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_wstrb = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && mc > 0; i++) tick();
    out_ready = 1'b0;
    chk("drain_done", EW'(mc), '0);
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] a,
                        input logic h, input logic ok, input logic [DW-1:0] d);
    lk_addr = a;
    #1;
    chk({tag, "_hit"}, EW'(lk_hit), EW'(h));
    chk({tag, "_ok"}, EW'(lk_fwd_ok), EW'(ok));
    chk({tag, "_data"}, EW'(lk_data), EW'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_wstrb  = '0;
    out_ready = 1'b0;
    lk_addr   = '0;
    repeat (2) tick();
    resetn = 1'b1;

    // Reset state.
    lookup("rst_lk", 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_in_ready", EW'(in_ready), EW'(1));
    chk("rst_out", {out_valid, out_addr, out_data, out_wstrb}, '0);
    chk("rst_count", EW'(count), '0);

    // 1: fill, overflow attempt, ordered drain.
    for (int i = 0; i < DEPTH; i++)
      push(32'h1000 + 32'(i * 4), $urandom, 4'hF);
    chk("t1_full", EW'(full), EW'(1));
    chk("t1_in_ready", EW'(in_ready), EW'(0));
    chk("t1_count", EW'(count), EW'(4));
    push(32'h2000, 32'hDEADDEAD, 4'hF);
    chk("t1_count_after_ovf", EW'(count), EW'(4));
    drain();
    chk("t1_empty", EW'(empty), EW'(1));

    // 2: steady stream, 20 cycles of concurrent push and pop.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_addr  = 32'h3000 + 32'(i * 4);
      in_data  = $urandom;
      in_wstrb = 4'(($urandom_range(1, 15)));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // 3: two partial stores merge into one full word.
    push(32'h100, 32'h0000BEEF, 4'b0011);
    push(32'h102, 32'hCAFE0000, 4'b1100);
    lookup("t3", 32'h100, 1'b1, 1'b1, 32'hCAFEBEEF);
    drain();

    // 4: youngest store wins per lane; neighbouring word misses.
    push(32'h200, 32'h11111111, 4'b1111);
    push(32'h200, 32'h00000022, 4'b0001);
    lookup("t4", 32'h200, 1'b1, 1'b1, 32'h11111122);
    lookup("t4_miss", 32'h204, 1'b0, 1'b0, 32'h0);
    drain();

    // 5: same-cycle push is invisible, visible one cycle later; partial cover.
    lk_addr  = 32'h300;
    in_valid = 1'b1;
    in_addr  = 32'h300;
    in_data  = 32'h000000AA;
    in_wstrb = 4'b0001;
    #1;
    chk("t5_same_cycle_hit", EW'(lk_hit), EW'(0));
    tick();
    in_valid = 1'b0;
    lookup("t5", 32'h300, 1'b1, 1'b0, 32'h000000AA);
    drain();

    // 6: reset mid-traffic discards queued entries.
    push(32'h400, 32'h44444444, 4'hF);
    push(32'h404, 32'h55555555, 4'hF);
    push(32'h408, 32'h66666666, 4'hF);
    lookup("t6_pre", 32'h400, 1'b1, 1'b1, 32'h44444444);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_count", EW'(count), '0);
    chk("t6_out_valid", EW'(out_valid), '0);
    lookup("t6_post", 32'h400, 1'b0, 1'b0, 32'h0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
